// File: rtl/drp_pkg.sv
// Shared constants for the DRP register bank:
// address map, field positions, error bits, reset values.
package drp_pkg;

  localparam logic [6:0] ADDR_FB1   = 7'h14;
  localparam logic [6:0] ADDR_DIV   = 7'h16;
  localparam logic [6:0] ADDR_LOCK0 = 7'h18;
  localparam logic [6:0] ADDR_LOCK1 = 7'h19;
  localparam logic [6:0] ADDR_LOCK2 = 7'h1A;
  localparam logic [6:0] ADDR_PWR   = 7'h28;
  localparam logic [6:0] ADDR_FILT0 = 7'h4E;
  localparam logic [6:0] ADDR_FILT1 = 7'h4F;

  localparam int HI_LSB    = 6;
  localparam int LO_LSB    = 0;
  localparam int PH_LSB    = 13;
  localparam int DLY_LSB   = 0;
  localparam int NOCNT_BIT = 6;
  localparam int EDGE_BIT  = 7;
  localparam int MX_LSB    = 8;
  localparam int DIVNC_BIT = 12;

  localparam int ERR_ADDR = 0;
  localparam int ERR_COLL = 1;
  localparam int ERR_MX   = 2;

  localparam logic [15:0] POWER_RST = 16'h1111;
  localparam logic [9:0]  DUTY_RST  = 10'd500;

  function automatic logic [6:0] clk_addr(input int ch);
    case (ch)
      0:       return 7'h08;
      1:       return 7'h0A;
      2:       return 7'h0C;
      3:       return 7'h0E;
      4:       return 7'h10;
      5:       return 7'h06;
      6:       return 7'h12;
      default: return ADDR_FB1;
    endcase
  endfunction

  // A counter field of zero stands for a count of 64.
  function automatic logic [6:0] field64(input logic [5:0] f);
    return (f == 6'd0) ? 7'd64 : {1'b0, f};
  endfunction

endpackage

// File: rtl/drp_reg_bank_if.sv
// DRP access bus between a controller
// and the register bank.
interface drp_reg_bank_if;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;

  modport master (
    output DADDR, DEN, DWE, DI,
    input  DO, DRDY
  );

  modport slave (
    input  DADDR, DEN, DWE, DI,
    output DO, DRDY
  );
endinterface

// File: rtl/drp_clk_decode.sv
// Decodes one ClkReg1/ClkReg2 pair into
// divide, duty (1/1000) and phase (1/8 VCO).
module drp_clk_decode
  import drp_pkg::*;
(
  input  logic [5:0] hi_f,
  input  logic [5:0] lo_f,
  input  logic [2:0] ph_f,
  input  logic [5:0] dly,
  input  logic       edge_b,
  input  logic       nocnt,
  output logic [7:0] divide,
  output logic [9:0] duty,
  output logic [8:0] phase
);

  logic [6:0]  hi;
  logic [6:0]  lo;
  logic [7:0]  sum;
  logic [17:0] num;
  logic [17:0] den;

  assign hi  = field64(hi_f);
  assign lo  = field64(lo_f);
  assign sum = 8'(hi) + 8'(lo);
  assign num = (18'({hi, 1'b0}) + 18'(edge_b))
             * 18'd1000;
  assign den = 18'({sum, 1'b0});

  assign divide = nocnt ? 8'd1 : sum;
  assign duty   = nocnt ? DUTY_RST
                        : 10'(num / den);
  assign phase  = {dly, ph_f};

endmodule

// File: rtl/drp_reg_bank.sv
// DRP register bank for the PLL/MMCM model:
// register file, access FSM, decoded settings.
module drp_reg_bank
  import drp_pkg::*;
#(
  parameter int NUM_CLKOUT   = 7,
  parameter int DRDY_LATENCY = 2
)(
  input  logic                    DCLK,
  input  logic                    RST_N,
  input  logic                    PWRDWN,
  input  logic                    ERR_CLR,
  drp_reg_bank_if.slave           drp,
  output logic [2:0]              ERR,
  output logic [8*NUM_CLKOUT-1:0] CLKOUT_DIVIDE,
  output logic [10*NUM_CLKOUT-1:0] CLKOUT_DUTY,
  output logic [9*NUM_CLKOUT-1:0] CLKOUT_PHASE,
  output logic [7:0]              FB_MULT,
  output logic [8:0]              FB_PHASE,
  output logic [7:0]              DIVCLK_DIVIDE
);

  localparam int NS = NUM_CLKOUT + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] LAT_M1 =
    4'(DRDY_LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] di_q;
  logic [15:0] do_q;
  logic        drdy_q;
  logic [2:0]  err_q;

  logic [15:0] r1   [NS];
  logic [15:0] r2   [NS];
  logic [15:0] r1_n [NS];
  logic [15:0] r2_n [NS];
  logic [15:0] div_r;
  logic [15:0] pwr_r;
  logic [15:0] filt0_r;
  logic [15:0] filt1_r;
  logic [15:0] lock_r [3];

  logic [7:0]  div_n  [NS];
  logic [8:0]  ph_n   [NS];
  logic [9:0]  duty_n [NUM_CLKOUT];
  logic [7:0]  div_q  [NS];
  logic [8:0]  ph_q   [NS];
  logic [9:0]  duty_q [NUM_CLKOUT];
  logic [7:0]  dclk_q;
  logic [7:0]  dclk_sum;

  logic [6:0]  a_c;
  logic        we_c;
  logic [15:0] di_c;
  logic [NS-1:0] hit1;
  logic [NS-1:0] hit2;
  logic        misc_hit;
  logic        valid;
  logic        den_ok;
  logic        start;
  logic        commit;
  logic        wr;
  logic        mx_bad;
  logic [15:0] rd_data;
  logic [2:0]  err_set;

  function automatic logic [6:0] slot_addr(
    input int k
  );
    return (k == NUM_CLKOUT) ? ADDR_FB1
                             : clk_addr(k);
  endfunction

  // With latency 1 the live bus is committed
  // directly; otherwise the latched copy is.
  assign a_c  = (state == S_IDLE) ? drp.DADDR : addr_q;
  assign we_c = (state == S_IDLE) ? drp.DWE   : we_q;
  assign di_c = (state == S_IDLE) ? drp.DI    : di_q;

  assign den_ok = drp.DEN & ~PWRDWN;
  assign start  = den_ok & (state == S_IDLE);
  assign commit = ~PWRDWN &
    ((start & (DRDY_LATENCY == 1)) |
     ((state == S_BUSY) & (cnt == LAT_M1)));

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int k = 0; k < NS; k++) begin
      hit1[k] = (a_c == slot_addr(k));
      hit2[k] = (a_c == slot_addr(k) + 7'd1);
    end
  end

  assign misc_hit = a_c inside {
    ADDR_DIV, ADDR_LOCK0, ADDR_LOCK1, ADDR_LOCK2,
    ADDR_PWR, ADDR_FILT0, ADDR_FILT1};
  assign valid  = (|hit1) | (|hit2) | misc_hit;
  assign wr     = commit & we_c & valid;
  assign mx_bad = wr & (|hit2) &
                  (|di_c[MX_LSB+:2]);

  always_comb begin
    err_set = '0;
    err_set[ERR_ADDR] = commit & ~valid;
    err_set[ERR_COLL] = den_ok & (state != S_IDLE);
    err_set[ERR_MX]   = mx_bad;
  end

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      r1_n[k] = (wr && hit1[k]) ? di_c : r1[k];
      r2_n[k] = (wr && hit2[k]) ? di_c : r2[k];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NS; k++) begin
      if (hit1[k]) rd_data = r1[k];
      if (hit2[k]) rd_data = r2[k];
    end
    case (a_c)
      ADDR_DIV:   rd_data = div_r;
      ADDR_LOCK0: rd_data = lock_r[0];
      ADDR_LOCK1: rd_data = lock_r[1];
      ADDR_LOCK2: rd_data = lock_r[2];
      ADDR_PWR:   rd_data = pwr_r;
      ADDR_FILT0: rd_data = filt0_r;
      ADDR_FILT1: rd_data = filt1_r;
      default:    ;
    endcase
  end

  assign dclk_sum =
    8'(field64(di_c[HI_LSB+:6])) +
    8'(field64(di_c[LO_LSB+:6]));

  for (genvar k = 0; k < NS; k++) begin : g_dec
    if (k < NUM_CLKOUT) begin : g_ch
      drp_clk_decode u_dec (
        .hi_f   (r1_n[k][HI_LSB+:6]),
        .lo_f   (r1_n[k][LO_LSB+:6]),
        .ph_f   (r1_n[k][PH_LSB+:3]),
        .dly    (r2_n[k][DLY_LSB+:6]),
        .edge_b (r2_n[k][EDGE_BIT]),
        .nocnt  (r2_n[k][NOCNT_BIT]),
        .divide (div_n[k]),
        .duty   (duty_n[k]),
        .phase  (ph_n[k])
      );
    end else begin : g_fb
      logic [9:0] fb_duty_unused;
      drp_clk_decode u_dec (
        .hi_f   (r1_n[k][HI_LSB+:6]),
        .lo_f   (r1_n[k][LO_LSB+:6]),
        .ph_f   (r1_n[k][PH_LSB+:3]),
        .dly    (r2_n[k][DLY_LSB+:6]),
        .edge_b (r2_n[k][EDGE_BIT]),
        .nocnt  (r2_n[k][NOCNT_BIT]),
        .divide (div_n[k]),
        .duty   (fb_duty_unused),
        .phase  (ph_n[k])
      );
    end
  end

  always_ff @(posedge DCLK) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      di_q    <= '0;
      do_q    <= '0;
      drdy_q  <= 1'b0;
      err_q   <= '0;
      div_r   <= '0;
      pwr_r   <= POWER_RST;
      filt0_r <= '0;
      filt1_r <= '0;
      dclk_q  <= 8'd1;
      for (int i = 0; i < 3; i++) lock_r[i] <= '0;
      for (int k = 0; k < NS; k++) begin
        r1[k]    <= '0;
        r2[k]    <= '0;
        div_q[k] <= 8'd1;
        ph_q[k]  <= '0;
      end
      for (int k = 0; k < NUM_CLKOUT; k++)
        duty_q[k] <= DUTY_RST;
    end else begin
      drdy_q <= 1'b0;
      do_q   <= '0;
      err_q  <= (err_q & ~{3{ERR_CLR}}) | err_set;
      if (PWRDWN) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (drp.DEN) begin
            addr_q <= drp.DADDR;
            we_q   <= drp.DWE;
            di_q   <= drp.DI;
            cnt    <= 4'd1;
            state  <= (DRDY_LATENCY == 1) ? S_DONE
                                          : S_BUSY;
          end
          S_BUSY: begin
            cnt <= cnt + 4'd1;
            if (cnt == LAT_M1) state <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
      if (commit) begin
        drdy_q <= 1'b1;
        do_q   <= (we_c || !valid) ? '0 : rd_data;
      end
      if (wr) begin
        for (int k = 0; k < NS; k++) begin
          r1[k] <= r1_n[k];
          r2[k] <= r2_n[k];
          if (hit1[k] || hit2[k]) begin
            div_q[k] <= div_n[k];
            if (!(hit2[k] && mx_bad))
              ph_q[k] <= ph_n[k];
          end
        end
        for (int k = 0; k < NUM_CLKOUT; k++)
          if (hit1[k] || hit2[k])
            duty_q[k] <= duty_n[k];
        case (a_c)
          ADDR_DIV: begin
            div_r  <= di_c;
            dclk_q <= di_c[DIVNC_BIT] ? 8'd1
                                      : dclk_sum;
          end
          ADDR_LOCK0: lock_r[0] <= di_c;
          ADDR_LOCK1: lock_r[1] <= di_c;
          ADDR_LOCK2: lock_r[2] <= di_c;
          ADDR_PWR:   pwr_r     <= di_c;
          ADDR_FILT0: filt0_r   <= di_c;
          ADDR_FILT1: filt1_r   <= di_c;
          default:    ;
        endcase
      end
    end
  end

  assign drp.DO   = PWRDWN ? '0 : do_q;
  assign drp.DRDY = drdy_q & ~PWRDWN;
  assign ERR      = err_q;

  for (genvar k = 0; k < NUM_CLKOUT; k++) begin : g_out
    assign CLKOUT_DIVIDE[8*k+:8]  = div_q[k];
    assign CLKOUT_DUTY[10*k+:10]  = duty_q[k];
    assign CLKOUT_PHASE[9*k+:9]   = ph_q[k];
  end

  assign FB_MULT       = div_q[NUM_CLKOUT];
  assign FB_PHASE      = ph_q[NUM_CLKOUT];
  assign DIVCLK_DIVIDE = dclk_q;

endmodule

// File: tb/tb_drp_reg_bank.sv
// Bench for drp_reg_bank: directed table, corner
// sequences and random accesses against a model.
module tb_drp_reg_bank;

  localparam int NCH = 7;
  localparam int NT  = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwrdwn = 1'b0;
  logic err_clr = 1'b0;
  logic [2:0] err;
  logic [8*NCH-1:0] cdiv;
  logic [10*NCH-1:0] cduty;
  logic [9*NCH-1:0] cph;
  logic [7:0] fbm;
  logic [8:0] fbp;
  logic [7:0] dclkd;

  int checks = 0;
  int errors = 0;

  drp_reg_bank_if bus ();

  always #5 clk = ~clk;

  drp_reg_bank #(
    .NUM_CLKOUT   (NCH),
    .DRDY_LATENCY (2)
  ) dut (
    .DCLK          (clk),
    .RST_N         (rst_n),
    .PWRDWN        (pwrdwn),
    .ERR_CLR       (err_clr),
    .drp           (bus),
    .ERR           (err),
    .CLKOUT_DIVIDE (cdiv),
    .CLKOUT_DUTY   (cduty),
    .CLKOUT_PHASE  (cph),
    .FB_MULT       (fbm),
    .FB_PHASE      (fbp),
    .DIVCLK_DIVIDE (dclkd)
  );

  int m_mem [128];
  int m_div [8];
  int m_duty [8];
  int m_ph [8];
  int m_dclk;
  logic [2:0] m_err;
  int chaddr [8] = '{'h08, 'h0A, 'h0C, 'h0E,
                     'h10, 'h06, 'h12, 'h14};
  int pool [26] = '{'h08, 'h09, 'h0A, 'h0B, 'h0C,
    'h0D, 'h0E, 'h0F, 'h10, 'h11, 'h06, 'h07,
    'h12, 'h13, 'h14, 'h15, 'h16, 'h18, 'h19,
    'h1A, 'h28, 'h4E, 'h4F, 'h30, 'h17, 'h00};

  typedef struct {
    bit          we;
    logic [6:0]  a;
    logic [15:0] d;
    logic [15:0] e_do;
    logic [2:0]  e_err;
    int          ch;
    int          e_div;
    int          e_duty;
    int          e_ph;
  } vec_t;

  vec_t tbl [NT];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic int f64(input int f);
    return (f == 0) ? 64 : f;
  endfunction

  function automatic int slot_of(input int a);
    for (int s = 0; s < 8; s++)
      if (a == chaddr[s] || a == chaddr[s] + 1)
        return s;
    return -1;
  endfunction

  function automatic bit is_valid(input int a);
    return slot_of(a) >= 0 || a == 'h16 ||
      a == 'h18 || a == 'h19 || a == 'h1A ||
      a == 'h28 || a == 'h4E || a == 'h4F;
  endfunction

  task automatic dec(input int r1, input int r2,
                     output int dv, output int dt,
                     output int ph);
    int hi;
    int lo;
    hi = f64((r1 >> 6) & 63);
    lo = f64(r1 & 63);
    if (((r2 >> 6) & 1) == 1) begin
      dv = 1;
      dt = 500;
    end else begin
      dv = hi + lo;
      dt = ((2 * hi + ((r2 >> 7) & 1)) * 1000)
           / (2 * (hi + lo));
    end
    ph = (r2 & 63) * 8 + ((r1 >> 13) & 7);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 0;
    m_mem['h28] = 'h1111;
    for (int s = 0; s < 8; s++) begin
      m_div[s]  = 1;
      m_duty[s] = 500;
      m_ph[s]   = 0;
    end
    m_dclk = 1;
    m_err  = 3'b000;
  endtask

  task automatic model_op(input bit we, input int a,
                          input int d,
                          output int rdo);
    int s;
    int dv;
    int dt;
    int ph;
    bit mx;
    rdo = 0;
    s = slot_of(a);
    if (!is_valid(a)) begin
      m_err[0] = 1'b1;
      return;
    end
    if (!we) begin
      rdo = m_mem[a];
      return;
    end
    m_mem[a] = d;
    if (a == 'h16)
      m_dclk = (((d >> 12) & 1) == 1) ? 1 :
        f64((d >> 6) & 63) + f64(d & 63);
    if (s >= 0) begin
      mx = (a == chaddr[s] + 1) &&
           (((d >> 8) & 3) != 0);
      if (mx) m_err[2] = 1'b1;
      dec(m_mem[chaddr[s]], m_mem[chaddr[s] + 1],
          dv, dt, ph);
      m_div[s]  = dv;
      m_duty[s] = dt;
      if (!mx) m_ph[s] = ph;
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("%s_div%0d", tag, c),
          32'(cdiv[8*c+:8]), m_div[c]);
      chk($sformatf("%s_duty%0d", tag, c),
          32'(cduty[10*c+:10]), m_duty[c]);
      chk($sformatf("%s_ph%0d", tag, c),
          32'(cph[9*c+:9]), m_ph[c]);
    end
    chk({tag, "_fbm"}, 32'(fbm), m_div[7]);
    chk({tag, "_fbp"}, 32'(fbp), m_ph[7]);
    chk({tag, "_dclk"}, 32'(dclkd), m_dclk);
    chk({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  task automatic drp_op(input bit we,
                        input logic [6:0] a,
                        input logic [15:0] d,
                        output logic [15:0] rdo);
    bit got;
    int lat;
    @(posedge clk);
    #1;
    bus.DEN   = 1'b1;
    bus.DWE   = we;
    bus.DADDR = a;
    bus.DI    = d;
    @(posedge clk);
    #1;
    bus.DEN   = 1'b0;
    bus.DWE   = 1'b0;
    bus.DADDR = 7'($urandom);
    bus.DI    = 16'($urandom);
    got = 1'b0;
    lat = 0;
    rdo = '0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (bus.DRDY) begin
        got = 1'b1;
        lat = i;
        rdo = bus.DO;
      end else begin
        chk("do_idle", 32'(bus.DO), 0);
      end
    end
    chk("drdy_seen", 32'(got), 1);
    chk("drdy_lat", lat, 2);
    @(negedge clk);
    chk("drdy_pulse", 32'(bus.DRDY), 0);
  endtask

  task automatic count_drdy(input int n,
                            output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.DRDY) cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] rdo;
    int n;
    int mdo;
    bit we;
    int a;
    int d;

    tbl[0]  = '{1, 7'h08, 16'h0083, 0, 0, 0, 5, 400, 0};
    tbl[1]  = '{1, 7'h09, 16'h0000, 0, 0, 0, 5, 400, 0};
    tbl[2]  = '{1, 7'h09, 16'h0080, 0, 0, 0, 5, 500, 0};
    tbl[3]  = '{1, 7'h08, 16'h6082, 0, 0, 0, 4, 625, 3};
    tbl[4]  = '{1, 7'h09, 16'h0005, 0, 0, 0, 4, 500, 43};
    tbl[5]  = '{0, 7'h08, 16'h0000, 16'h6082, 0,
                0, 4, 500, 43};
    tbl[6]  = '{1, 7'h0A, 16'h0042, 0, 0, 1, 3, 333, 0};
    tbl[7]  = '{1, 7'h0B, 16'h0040, 0, 0, 1, 1, 500, 0};
    tbl[8]  = '{1, 7'h06, 16'h0000, 0, 0, 5, 128, 500, 0};
    tbl[9]  = '{1, 7'h07, 16'h0302, 0, 3'b100,
                5, 128, 500, 0};
    tbl[10] = '{0, 7'h07, 16'h0000, 16'h0302, 3'b100,
                5, 128, 500, 0};

    bus.DEN   = 1'b0;
    bus.DWE   = 1'b0;
    bus.DADDR = '0;
    bus.DI    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    check_all("rst");
    chk("rst_drdy", 32'(bus.DRDY), 0);
    chk("rst_do", 32'(bus.DO), 0);

    for (int i = 0; i < NT; i++) begin
      drp_op(tbl[i].we, tbl[i].a, tbl[i].d, rdo);
      chk($sformatf("t%0d_do", i), 32'(rdo),
          32'(tbl[i].e_do));
      chk($sformatf("t%0d_err", i), 32'(err),
          32'(tbl[i].e_err));
      chk($sformatf("t%0d_div", i),
          32'(cdiv[8*tbl[i].ch+:8]), tbl[i].e_div);
      chk($sformatf("t%0d_duty", i),
          32'(cduty[10*tbl[i].ch+:10]), tbl[i].e_duty);
      chk($sformatf("t%0d_ph", i),
          32'(cph[9*tbl[i].ch+:9]), tbl[i].e_ph);
    end

    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("errclr", 32'(err), 0);

    drp_op(1, 7'h14, 16'h0104, rdo);
    drp_op(1, 7'h16, 16'h1000, rdo);
    chk("fb_mult", 32'(fbm), 8);
    chk("divclk_nc", 32'(dclkd), 1);
    drp_op(1, 7'h16, 16'h0042, rdo);
    chk("divclk", 32'(dclkd), 3);
    drp_op(1, 7'h15, 16'h0003, rdo);
    chk("fb_phase", 32'(fbp), 24);
    chk("fb_mult2", 32'(fbm), 8);

    drp_op(1, 7'h30, 16'hBEEF, rdo);
    chk("bad_err", 32'(err), 32'(3'b001));
    chk("bad_div0", 32'(cdiv[7:0]), 4);
    chk("bad_ph0", 32'(cph[8:0]), 43);
    drp_op(0, 7'h30, 16'h0000, rdo);
    chk("bad_rd", 32'(rdo), 0);

    @(posedge clk);
    #1;
    bus.DEN = 1'b1; bus.DWE = 1'b1;
    bus.DADDR = 7'h0C; bus.DI = 16'h0042;
    @(posedge clk);
    #1;
    bus.DADDR = 7'h0E; bus.DI = 16'h00C3;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.DEN = 1'b0; bus.DWE = 1'b0;
    err_clr = 1'b0;
    count_drdy(8, n);
    chk("coll_drdy", n, 1);
    chk("coll_err", 32'(err), 32'(3'b010));
    chk("coll_ch2", 32'(cdiv[23:16]), 3);
    chk("coll_ch3", 32'(cdiv[31:24]), 1);

    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(posedge clk);
    #1;
    bus.DEN = 1'b1; bus.DWE = 1'b1;
    bus.DADDR = 7'h10; bus.DI = 16'h0083;
    @(posedge clk);
    #1;
    bus.DEN = 1'b0;
    pwrdwn = 1'b1;
    @(posedge clk);
    #1 pwrdwn = 1'b0;
    count_drdy(6, n);
    chk("pd_abort_drdy", n, 0);
    chk("pd_abort_ch4", 32'(cdiv[39:32]), 1);
    @(posedge clk);
    #1;
    pwrdwn = 1'b1;
    bus.DEN = 1'b1;
    @(posedge clk);
    #1 bus.DEN = 1'b0;
    count_drdy(4, n);
    pwrdwn = 1'b0;
    chk("pd_den_drdy", n, 0);
    chk("pd_err", 32'(err), 0);
    chk("pd_ch4", 32'(cdiv[39:32]), 1);

    @(posedge clk);
    #1;
    bus.DEN = 1'b1; bus.DWE = 1'b1;
    bus.DADDR = 7'h12; bus.DI = 16'h0083;
    @(posedge clk);
    #1;
    bus.DEN = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_drdy(6, n);
    chk("rstp_drdy", n, 0);
    model_reset();
    check_all("rstp");
    drp_op(0, 7'h28, 16'h0000, rdo);
    chk("rd_pwr", 32'(rdo), 32'h1111);

    for (int i = 0; i < 300; i++) begin
      a  = pool[$urandom_range(0, 25)];
      we = ($urandom_range(0, 2) != 0);
      d  = int'($urandom & 32'hFFFF);
      if ($urandom_range(0, 3) != 0) d = d & ~'h300;
      if (i % 50 == 49) begin
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        m_err = 3'b000;
      end
      model_op(we, a, d, mdo);
      drp_op(we, 7'(a), 16'(d), rdo);
      chk($sformatf("r%0d_do", i), 32'(rdo), mdo);
      check_all($sformatf("r%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
